// File: rtl/hps_mgmt_pkg.sv
// Shared definitions for the HPS management bridge: FSM state encoding,
// watchdog counter width and the read data returned on a timeout.
package hps_mgmt_pkg;

  // Bridge FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_REQ  = 2'd1;
  localparam logic [1:0] ST_RD_WAIT = 2'd2;
  localparam logic [1:0] ST_WR_REQ  = 2'd3;

  // Watchdog counter width; TIMEOUT_CYCLES must fit in it
  localparam int WDOG_W = 16;

  // Read data handed to the host when a read times out
  localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/hps_mgmt_watchdog.sv
// Transaction watchdog: a cycle counter that is cleared when a strobe is
// accepted and counts every busy cycle. expired is high on the busy cycle
// where the count equals TIMEOUT_CYCLES.
module hps_mgmt_watchdog
  import hps_mgmt_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic clear,
  input  logic busy,
  output logic expired
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT_CYCLES);

  logic [WDOG_W-1:0] cnt;

  // Count busy cycles since the last accepted strobe
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (busy) begin
      cnt <= cnt + WDOG_W'(1);
    end
  end

  assign expired = busy && (cnt == LIMIT);

endmodule

// File: rtl/hps_mgmt_bridge.sv
// HPS management bridge: turns one-cycle host read/write strobes into a
// single Avalon-MM transaction on the mgmt_* master and stalls the host
// with io_wait until it completes.
// Optional feature: define MGMT_WATCHDOG_EN to compile in the transaction
// watchdog (timeout_err, TIMEOUT_DATA on timed-out reads).
//
// Handshake: a command (mgmt_read / mgmt_write) with its address and data
// is held stable until a cycle where mgmt_waitrequest is 0; that cycle is
// the acceptance. After a read is accepted, the first cycle with
// mgmt_readdatavalid = 1 carries the data. Only abort (or a watchdog
// timeout) may withdraw a command that has not been accepted.
module hps_mgmt_bridge
  import hps_mgmt_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        abort,
  input  logic        ext_rd,
  input  logic        ext_wr,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_dout,
  output logic [31:0] ext_din,
  output logic        io_wait,
  output logic [31:0] mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        mgmt_read,
  output logic        mgmt_write,
  input  logic        mgmt_waitrequest,
  input  logic [31:0] mgmt_readdata,
  input  logic        mgmt_readdatavalid,
  output logic        timeout_err,
  output logic [1:0]  dbg_state
);

  logic [1:0]  state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] din_q;
  logic        strobe_ok;
  logic        wd_fire;

  // A strobe is taken only in IDLE and never on an abort cycle
  assign strobe_ok = (state == ST_IDLE) && !abort && (ext_rd || ext_wr);

`ifdef MGMT_WATCHDOG_EN
  logic wd_expired;
  logic done_now;
  logic terr_q;

  // A normal completion on the limit cycle wins over the timeout
  assign done_now = ((state == ST_RD_REQ)  && !mgmt_waitrequest) ||
                    ((state == ST_RD_WAIT) && mgmt_readdatavalid) ||
                    ((state == ST_WR_REQ)  && !mgmt_waitrequest);
  assign wd_fire  = wd_expired && !done_now;

  hps_mgmt_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .clear   (strobe_ok),
    .busy    (state != ST_IDLE),
    .expired (wd_expired)
  );

  // Sticky timeout flag, cleared by the next accepted strobe
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      terr_q <= 1'b0;
    end else if (strobe_ok) begin
      terr_q <= 1'b0;
    end else if (!abort && wd_fire) begin
      terr_q <= 1'b1;
    end
  end

  assign timeout_err = terr_q;
`else
  logic [WDOG_W-1:0] unused_timeout;

  assign unused_timeout = WDOG_W'(TIMEOUT_CYCLES);
  assign wd_fire        = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  // Transaction sequencer: latch request, hold command, collect read data
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      din_q   <= '0;
    end else if (abort) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ext_rd || ext_wr) begin
            addr_q  <= ext_addr;
            wdata_q <= ext_dout;
            state   <= ext_rd ? ST_RD_REQ : ST_WR_REQ;
          end
        end
        ST_RD_REQ: begin
          if (!mgmt_waitrequest) begin
            state <= ST_RD_WAIT;
          end else if (wd_fire) begin
            din_q <= TIMEOUT_DATA;
            state <= ST_IDLE;
          end
        end
        ST_RD_WAIT: begin
          if (mgmt_readdatavalid) begin
            din_q <= mgmt_readdata;
            state <= ST_IDLE;
          end else if (wd_fire) begin
            din_q <= TIMEOUT_DATA;
            state <= ST_IDLE;
          end
        end
        ST_WR_REQ: begin
          if (!mgmt_waitrequest || wd_fire) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mgmt_read      = (state == ST_RD_REQ);
  assign mgmt_write     = (state == ST_WR_REQ);
  assign io_wait        = (state != ST_IDLE);
  assign mgmt_address   = addr_q;
  assign mgmt_writedata = wdata_q;
  assign ext_din        = din_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_hps_mgmt_bridge.sv
// Testbench for hps_mgmt_bridge: cycle-by-cycle vector table plus
// hand-written sequences for watchdog / stall, and async reset.
module tb_hps_mgmt_bridge;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        abort;
  logic        ext_rd;
  logic        ext_wr;
  logic [31:0] ext_addr;
  logic [31:0] ext_dout;
  logic [31:0] ext_din;
  logic        io_wait;
  logic [31:0] mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_read;
  logic        mgmt_write;
  logic        mgmt_waitrequest;
  logic [31:0] mgmt_readdata;
  logic        mgmt_readdatavalid;
  logic        timeout_err;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        ab;
    logic        wq;
    logic        rv;
    logic [31:0] addr;
    logic [31:0] dout;
    logic [31:0] rdata;
    logic        e_wait;
    logic        e_rd;
    logic        e_wr;
    logic [31:0] e_din;
    logic        ck_bus;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vq[$];

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  hps_mgmt_bridge #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_sys            (clk_sys),
    .reset_n            (reset_n),
    .abort              (abort),
    .ext_rd             (ext_rd),
    .ext_wr             (ext_wr),
    .ext_addr           (ext_addr),
    .ext_dout           (ext_dout),
    .ext_din            (ext_din),
    .io_wait            (io_wait),
    .mgmt_address       (mgmt_address),
    .mgmt_writedata     (mgmt_writedata),
    .mgmt_read          (mgmt_read),
    .mgmt_write         (mgmt_write),
    .mgmt_waitrequest   (mgmt_waitrequest),
    .mgmt_readdata      (mgmt_readdata),
    .mgmt_readdatavalid (mgmt_readdatavalid),
    .timeout_err        (timeout_err),
    .dbg_state          (dbg_state)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic ab,
                       input logic wq, input logic rv, input logic [31:0] addr,
                       input logic [31:0] dout, input logic [31:0] rdata);
    ext_rd             = rd;
    ext_wr             = wr;
    abort              = ab;
    mgmt_waitrequest   = wq;
    mgmt_readdatavalid = rv;
    ext_addr           = addr;
    ext_dout           = dout;
    mgmt_readdata      = rdata;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic add(input logic rd, input logic wr, input logic ab,
                     input logic wq, input logic rv, input logic [31:0] addr,
                     input logic [31:0] dout, input logic [31:0] rdata,
                     input logic e_wait, input logic e_rd, input logic e_wr,
                     input logic [31:0] e_din, input logic ck_bus,
                     input logic [31:0] e_addr, input logic [31:0] e_wdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.ab = ab; v.wq = wq; v.rv = rv;
    v.addr = addr; v.dout = dout; v.rdata = rdata;
    v.e_wait = e_wait; v.e_rd = e_rd; v.e_wr = e_wr; v.e_din = e_din;
    v.ck_bus = ck_bus; v.e_addr = e_addr; v.e_wdata = e_wdata;
    vq.push_back(v);
  endtask

  initial begin
    int n;

    // Read: accepted at once, two quiet cycles, then data -> io_wait high 4 cycles
    add(1,0,0,0,0, 32'h10, 32'h0, 32'h0,              1,1,0, 32'h0,        1, 32'h10, 32'h0);
    add(0,0,0,0,0, 32'h0,  32'h0, 32'h0,              1,0,0, 32'h0,        1, 32'h10, 32'h0);
    add(0,1,0,0,0, 32'h99, 32'h77, 32'h0,             1,0,0, 32'h0,        1, 32'h10, 32'h0);
    add(0,0,0,0,0, 32'h0,  32'h0, 32'h0,              1,0,0, 32'h0,        1, 32'h10, 32'h0);
    add(0,0,0,0,1, 32'h0,  32'h0, 32'hDEAD_BEEF,      0,0,0, 32'hDEAD_BEEF, 0, 32'h0, 32'h0);
    add(0,0,0,0,1, 32'h0,  32'h0, 32'h1111_1111,      0,0,0, 32'hDEAD_BEEF, 0, 32'h0, 32'h0);
    // Write: waitrequest high 3 cycles -> mgmt_write high 4 cycles, bus stable
    add(0,1,0,1,0, 32'h20, 32'h1234_5678, 32'h0,      1,0,1, 32'hDEAD_BEEF, 1, 32'h20, 32'h1234_5678);
    add(0,1,0,1,0, 32'hBAD0, 32'hBAD1, 32'h0,         1,0,1, 32'hDEAD_BEEF, 1, 32'h20, 32'h1234_5678);
    add(0,0,0,1,0, 32'h0,  32'h0, 32'h0,              1,0,1, 32'hDEAD_BEEF, 1, 32'h20, 32'h1234_5678);
    add(0,0,0,1,0, 32'h0,  32'h0, 32'h0,              1,0,1, 32'hDEAD_BEEF, 1, 32'h20, 32'h1234_5678);
    add(0,0,0,0,0, 32'h0,  32'h0, 32'h0,              0,0,0, 32'hDEAD_BEEF, 0, 32'h0, 32'h0);
    // Read and write strobed together: read wins, write dropped
    add(1,1,0,0,0, 32'h30, 32'hAAAA_5555, 32'h0,      1,1,0, 32'hDEAD_BEEF, 1, 32'h30, 32'hAAAA_5555);
    add(0,0,0,1,0, 32'h0,  32'h0, 32'h0,              1,1,0, 32'hDEAD_BEEF, 1, 32'h30, 32'hAAAA_5555);
    add(0,0,0,0,0, 32'h0,  32'h0, 32'h0,              1,0,0, 32'hDEAD_BEEF, 1, 32'h30, 32'hAAAA_5555);
    add(0,0,0,0,1, 32'h0,  32'h0, 32'h0BAD_F00D,      0,0,0, 32'h0BAD_F00D, 0, 32'h0, 32'h0);
    add(0,0,0,0,0, 32'h0,  32'h0, 32'h0,              0,0,0, 32'h0BAD_F00D, 0, 32'h0, 32'h0);
    // Abort in RD_WAIT, late valid ignored, abort beats strobe, abort in WR_REQ
    add(1,0,0,0,0, 32'h40, 32'h0, 32'h0,              1,1,0, 32'h0BAD_F00D, 1, 32'h40, 32'h0);
    add(0,0,0,0,0, 32'h0,  32'h0, 32'h0,              1,0,0, 32'h0BAD_F00D, 1, 32'h40, 32'h0);
    add(0,0,1,0,0, 32'h0,  32'h0, 32'h0,              0,0,0, 32'h0BAD_F00D, 0, 32'h0, 32'h0);
    add(0,0,0,0,1, 32'h0,  32'h0, 32'h5555_5555,      0,0,0, 32'h0BAD_F00D, 0, 32'h0, 32'h0);
    add(1,0,1,0,0, 32'h44, 32'h0, 32'h0,              0,0,0, 32'h0BAD_F00D, 0, 32'h0, 32'h0);
    add(0,1,0,1,0, 32'h50, 32'h5050, 32'h0,           1,0,1, 32'h0BAD_F00D, 1, 32'h50, 32'h5050);
    add(0,0,1,1,0, 32'h0,  32'h0, 32'h0,              0,0,0, 32'h0BAD_F00D, 0, 32'h0, 32'h0);
    // Minimum-latency write then read issued on the first free cycle
    add(0,1,0,0,0, 32'h60, 32'h0102_0304, 32'h0,      1,0,1, 32'h0BAD_F00D, 1, 32'h60, 32'h0102_0304);
    add(0,0,0,0,0, 32'h0,  32'h0, 32'h0,              0,0,0, 32'h0BAD_F00D, 0, 32'h0, 32'h0);
    add(1,0,0,0,0, 32'h70, 32'h0, 32'h0,              1,1,0, 32'h0BAD_F00D, 1, 32'h70, 32'h0);
    add(0,0,0,0,0, 32'h0,  32'h0, 32'h0,              1,0,0, 32'h0BAD_F00D, 1, 32'h70, 32'h0);
    add(0,0,0,0,1, 32'h0,  32'h0, 32'hCAFE_F00D,      0,0,0, 32'hCAFE_F00D, 0, 32'h0, 32'h0);

    // reset
    reset_n = 1'b0;
    drive(0,0,0,0,0, 32'h0, 32'h0, 32'h0);
    #22;
    chk("rst_io_wait", io_wait, 32'h0);
    chk("rst_read",    mgmt_read, 32'h0);
    chk("rst_write",   mgmt_write, 32'h0);
    chk("rst_din",     ext_din, 32'h0);
    chk("rst_addr",    mgmt_address, 32'h0);
    chk("rst_wdata",   mgmt_writedata, 32'h0);
    chk("rst_terr",    timeout_err, 32'h0);
    chk("rst_state",   dbg_state, 32'h0);
    reset_n = 1'b1;
    tick();

    // table
    foreach (vq[i]) begin
      drive(vq[i].rd, vq[i].wr, vq[i].ab, vq[i].wq, vq[i].rv,
            vq[i].addr, vq[i].dout, vq[i].rdata);
      tick();
      chk($sformatf("v%0d_io_wait", i), io_wait, 32'(vq[i].e_wait));
      chk($sformatf("v%0d_read", i),    mgmt_read, 32'(vq[i].e_rd));
      chk($sformatf("v%0d_write", i),   mgmt_write, 32'(vq[i].e_wr));
      chk($sformatf("v%0d_din", i),     ext_din, vq[i].e_din);
      chk($sformatf("v%0d_terr", i),    timeout_err, 32'h0);
      if (vq[i].ck_bus) begin
        chk($sformatf("v%0d_addr", i),  mgmt_address, vq[i].e_addr);
        chk($sformatf("v%0d_wdata", i), mgmt_writedata, vq[i].e_wdata);
      end
    end
    drive(0,0,0,0,0, 32'h0, 32'h0, 32'h0);
    tick();

`ifdef MGMT_WATCHDOG_EN
    // Watchdog: slave never accepts the read; limit 8 -> busy for 9 cycles
    drive(1,0,0,1,0, 32'h80, 32'h0, 32'h0);
    tick();
    drive(0,0,0,1,0, 32'h0, 32'h0, 32'h0);
    n = io_wait ? 1 : 0;
    for (int k = 0; k < 50 && io_wait; k++) begin
      tick();
      if (io_wait) n++;
    end
    chk("wd_busy_cycles", 32'(n), 32'd9);
    chk("wd_io_wait",     io_wait, 32'h0);
    chk("wd_read",        mgmt_read, 32'h0);
    chk("wd_din",         ext_din, 32'hFFFF_FFFF);
    chk("wd_terr_set",    timeout_err, 32'h1);
    tick();
    chk("wd_terr_sticky", timeout_err, 32'h1);
    drive(0,1,0,0,0, 32'h90, 32'h9, 32'h0);
    tick();
    chk("wd_terr_clear",  timeout_err, 32'h0);
    chk("wd_next_write",  mgmt_write, 32'h1);
    drive(0,0,0,0,0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("wd_next_done",   io_wait, 32'h0);
`else
    // No watchdog: a read that never returns data stalls until abort
    drive(1,0,0,0,0, 32'h80, 32'h0, 32'h0);
    tick();
    drive(0,0,0,0,0, 32'h0, 32'h0, 32'h0);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (io_wait) n++;
    end
    chk("hang_busy_cycles", 32'(n), 32'd20);
    chk("hang_terr",        timeout_err, 32'h0);
    chk("hang_din",         ext_din, 32'hCAFE_F00D);
    drive(0,0,1,0,0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("hang_abort",       io_wait, 32'h0);
    drive(0,0,0,0,0, 32'h0, 32'h0, 32'h0);
    tick();
`endif

    // Async reset in the middle of a stalled write
    drive(0,1,0,1,0, 32'hA0, 32'hA5A5_A5A5, 32'h0);
    tick();
    drive(0,0,0,1,0, 32'h0, 32'h0, 32'h0);
    chk("mw_write_on", mgmt_write, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mw_write",   mgmt_write, 32'h0);
    chk("mw_io_wait", io_wait, 32'h0);
    chk("mw_addr",    mgmt_address, 32'h0);
    chk("mw_wdata",   mgmt_writedata, 32'h0);
    chk("mw_din",     ext_din, 32'h0);
    chk("mw_state",   dbg_state, 32'h0);
    #3;
    reset_n = 1'b1;
    tick();
    chk("mw_after",   io_wait, 32'h0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
